ssram_arbiter: RTL and testbench
================================

# ssram_arbiter

Two-port arbiter and init sequencer for the single-port `ssram` data/instruction memory. It shares the memory between the core's instruction-fetch port (read-only) and its load/store port (read/write, byte-enabled). After reset it zero-fills the array, then grants one access per cycle with round-robin fairness. Requester byte addresses are translated to word indices, and out-of-range accesses return an error without touching memory.

## Interface
- `WIDTH`, 32: data width; a multiple of 8. `OFS = $clog2(WIDTH/8)`.
- `ADDR_BITS`, 16: memory holds `1<<ADDR_BITS` words; must match `ssram`.
- `INIT_EN`, 1: 1 zero-fills memory after reset; 0 goes straight to RUN.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `i_req_valid`  in  1  fetch request.
- `i_req_ready`  out  1  fetch request accepted this cycle.
- `i_req_addr`  in  32  fetch byte address.
- `i_rsp_valid`  out  1  fetch response.
- `i_rsp_rdata`  out  WIDTH  fetch read data.
- `i_rsp_err`  out  1  fetch address out of range.
- `d_req_valid`  in  1  data request.
- `d_req_ready`  out  1  data request accepted this cycle.
- `d_req_addr`  in  32  data byte address.
- `d_req_we`  in  1  1 = write, 0 = read.
- `d_req_be`  in  WIDTH/8  write byte enables.
- `d_req_wdata`  in  WIDTH  write data.
- `d_rsp_valid`  out  1  data response (read data or write ack).
- `d_rsp_rdata`  out  WIDTH  data read data; 0 for writes.
- `d_rsp_err`  out  1  data address out of range.
- `mem_address`  out  32  word index to `ssram.address`.
- `mem_write_data`  out  WIDTH  to `ssram.write_data`.
- `mem_write_byte_enable`  out  WIDTH/8  to `ssram.write_byte_enable`.
- `mem_write_enable`  out  1  to `ssram.write_enable`.
- `mem_read_enable`  out  1  to `ssram.read_enable`.
- `mem_read_data`  in  WIDTH  from `ssram.read_data`; registered, valid 1 cycle after the read.
- `init_done`  out  1  high once RUN is entered.

## Operation
- **FSM states:** INIT and RUN. Reset enters INIT if `INIT_EN`, otherwise RUN.
- **INIT:**
  - 16-bit-wide (`ADDR_BITS`) counter `icnt` counts from 0.
  - Drives `mem_address={0,icnt}`, `mem_write_data=0`, all byte enables 1, `mem_write_enable=1`, `mem_read_enable=0`.
  - Both `*_req_ready` are 0.
  - After writing word `(1<<ADDR_BITS)-1`, moves to RUN.
- **RUN, grant:**
  - Only one valid: that port is granted.
  - Both valid: the port not in `last_grant` is granted.
  - `last_grant` updates to the granted port on every grant. Its reset value is D, so I wins the first tie.
  - `x_req_ready` = grant to x. Ready may depend on valid; valid must not depend on ready.
- **Address translation:**
  - `word = addr >> OFS`.
  - Out of range if `addr[31:ADDR_BITS+OFS] != 0`.
  - `mem_address = {0, word[ADDR_BITS-1:0]}`.
  - Low `OFS` bits are ignored (no misalignment check).
- **Memory drive (combinational, same cycle as the handshake):**
  - In-range I grant: `mem_read_enable=1`.
  - In-range D read: `mem_read_enable=1`.
  - In-range D write: `mem_write_enable=1`, with `be` and `wdata` passed through.
  - Out of range, or no grant: both enables are 0.
- **Response tracking registers:** `rsp_pending`, `rsp_owner`, `rsp_err`, `rsp_wr`.
  - Every accepted request produces exactly one response on its own port.
  - Read in range: `rdata = mem_read_data`.
  - Write ack: `rdata = 0`.
  - Error: `err=1`, `rdata=0`, no memory access.
- Responses cannot be stalled; requesters must accept them.
- A D write with `be=0` is acked with no bytes changed.

## Timing
- **Reset values:** all `*_ready`, `*_rsp_valid`, `*_rsp_err` = 0; `*_rsp_rdata` = 0; `init_done` = 0 (1 if `!INIT_EN`); mem enables = 0; `icnt` = 0; FSM = INIT or RUN per `INIT_EN`.
- **Init duration:** exactly `1<<ADDR_BITS` cycles after reset release. `init_done` rises in the first RUN cycle.
- **Latency:** a handshake in cycle N gives `x_rsp_valid` high in cycle N+1, for exactly 1 cycle.
- **Throughput:** 1 request per cycle sustained. Responses for back-to-back grants arrive in grant order, one per cycle.
- **Contention:** under continuous contention, grants alternate I,D,I,D starting with I. A single active port is granted every cycle.
- **Reset mid-operation:** asserting `rst` asynchronously clears pending responses; `rsp_valid` drops immediately and the lost response is never delivered. INIT restarts from word 0.
- Requests presented during INIT wait with no handshake; they are not lost.

## Test plan
- **Init:** ADDR_BITS=4, INIT_EN=1, reset released. Expect 16 zero-writes to addresses 0..15, `init_done` rising on cycle 16, no ready during init. Then I read of 0x3C → `i_rsp_rdata=0`.
- **Byte write:** D write addr 0x8, be=4'b0101, wdata=0xAABBCCDD, then D read 0x8 → `rdata=0x00BB00DD`. Write ack has `rdata=0`, err=0.
- **Contention:** I and D both valid for 4 cycles → grants I,D,I,D. Each response lands on the correct port 1 cycle after its grant.
- **Out of range:** ADDR_BITS=4, D write 0x40 → `d_rsp_err=1` at N+1, mem enables 0 at N. Readback of word 0 is unchanged.
- **Reset mid-flight:** I read accepted, `rst` asserted before the next edge → `i_rsp_valid` never asserts. INIT restarts at word 0.
- **Back-to-back D reads:** reads of 0x0, 0x4, 0x8 in consecutive cycles → 3 consecutive responses in order with the correct data.

Source files
------------

// File: rtl/ssram_arbiter.sv
// Shares the single-port ssram between the fetch (I) and load/store (D) ports.
// Zero-fills the array after reset, then grants one access per cycle round-robin.
module ssram_arbiter #(
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 16,
    parameter int INIT_EN   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_req_valid,
    output logic                 i_req_ready,
    input  logic [31:0]          i_req_addr,
    output logic                 i_rsp_valid,
    output logic [WIDTH-1:0]     i_rsp_rdata,
    output logic                 i_rsp_err,
    input  logic                 d_req_valid,
    output logic                 d_req_ready,
    input  logic [31:0]          d_req_addr,
    input  logic                 d_req_we,
    input  logic [WIDTH/8-1:0]   d_req_be,
    input  logic [WIDTH-1:0]     d_req_wdata,
    output logic                 d_rsp_valid,
    output logic [WIDTH-1:0]     d_rsp_rdata,
    output logic                 d_rsp_err,
    output logic [31:0]          mem_address,
    output logic [WIDTH-1:0]     mem_write_data,
    output logic [WIDTH/8-1:0]   mem_write_byte_enable,
    output logic                 mem_write_enable,
    output logic                 mem_read_enable,
    input  logic [WIDTH-1:0]     mem_read_data,
    output logic                 init_done
);

    localparam int OFS = $clog2(WIDTH / 8);
    localparam int BEW = WIDTH / 8;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                 state_r;
    state_t                 state_s;
    logic [ADDR_BITS-1:0]   icnt_r;
    logic                   last_grant_r;   // 1'b1 = D was granted last
    logic                   rsp_pending_r;
    logic                   rsp_owner_r;    // 1'b1 = response belongs to D
    logic                   rsp_err_r;
    logic                   rsp_wr_r;
    logic                   gnt_i_s;
    logic                   gnt_d_s;
    logic                   oor_s;
    logic [31:0]            sel_addr_s;

    function automatic logic addr_out_of_range(input logic [31:0] a);
        return (a >> (ADDR_BITS + OFS)) != 32'd0;
    endfunction

    function automatic logic [31:0] word_index(input logic [31:0] a);
        logic [31:0] w;
        w = (a >> OFS) & ((32'd1 << ADDR_BITS) - 32'd1);
        return w;
    endfunction

    // Next-state, grant selection and combinational memory drive
    always_comb begin
        state_s               = state_r;
        gnt_i_s               = 1'b0;
        gnt_d_s               = 1'b0;
        oor_s                 = 1'b0;
        sel_addr_s            = 32'd0;
        mem_address           = 32'd0;
        mem_write_data        = {WIDTH{1'b0}};
        mem_write_byte_enable = {BEW{1'b0}};
        mem_write_enable      = 1'b0;
        mem_read_enable       = 1'b0;
        if (rst) begin
            case (state_r)
                ST_INIT: begin
                    mem_address           = {{(32-ADDR_BITS){1'b0}}, icnt_r};
                    mem_write_byte_enable = {BEW{1'b1}};
                    mem_write_enable      = 1'b1;
                    if (icnt_r == {ADDR_BITS{1'b1}}) begin
                        state_s = ST_RUN;
                    end else begin
                        state_s = ST_INIT;
                    end
                end
                ST_RUN: begin
                    // I wins a tie unless it was the last port served
                    gnt_i_s    = i_req_valid & (~d_req_valid | last_grant_r);
                    gnt_d_s    = d_req_valid & ~gnt_i_s;
                    sel_addr_s = gnt_d_s ? d_req_addr : i_req_addr;
                    oor_s      = addr_out_of_range(sel_addr_s);
                    if ((gnt_i_s | gnt_d_s) & ~oor_s) begin
                        mem_address = word_index(sel_addr_s);
                        if (gnt_d_s & d_req_we) begin
                            mem_write_enable      = 1'b1;
                            mem_write_byte_enable = d_req_be;
                            mem_write_data        = d_req_wdata;
                        end else begin
                            mem_read_enable = 1'b1;
                        end
                    end else begin
                        mem_address = 32'd0;
                    end
                end
                default: begin
                    state_s = ST_INIT;
                end
            endcase
        end else begin
            mem_write_enable = 1'b0;
            mem_read_enable  = 1'b0;
        end
    end

    // FSM state, init counter, round-robin history and response tracking
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= (INIT_EN != 0) ? ST_INIT : ST_RUN;
            icnt_r        <= {ADDR_BITS{1'b0}};
            last_grant_r  <= 1'b1;
            rsp_pending_r <= 1'b0;
            rsp_owner_r   <= 1'b0;
            rsp_err_r     <= 1'b0;
            rsp_wr_r      <= 1'b0;
        end else begin
            state_r       <= state_s;
            rsp_pending_r <= gnt_i_s | gnt_d_s;
            rsp_owner_r   <= gnt_d_s;
            rsp_err_r     <= (gnt_i_s | gnt_d_s) & oor_s;
            rsp_wr_r      <= gnt_d_s & d_req_we;
            if (state_r == ST_INIT) begin
                icnt_r <= icnt_r + {{(ADDR_BITS-1){1'b0}}, 1'b1};
            end else begin
                icnt_r <= icnt_r;
            end
            if (gnt_i_s) begin
                last_grant_r <= 1'b0;
            end else if (gnt_d_s) begin
                last_grant_r <= 1'b1;
            end else begin
                last_grant_r <= last_grant_r;
            end
        end
    end

    // Response steering: read data only for in-range reads, zero otherwise
    always_comb begin
        i_req_ready = gnt_i_s;
        d_req_ready = gnt_d_s;
        init_done   = (state_r == ST_RUN);
        i_rsp_valid = rsp_pending_r & ~rsp_owner_r;
        d_rsp_valid = rsp_pending_r & rsp_owner_r;
        i_rsp_err   = i_rsp_valid & rsp_err_r;
        d_rsp_err   = d_rsp_valid & rsp_err_r;
        i_rsp_rdata = {WIDTH{1'b0}};
        d_rsp_rdata = {WIDTH{1'b0}};
        if (rsp_pending_r & ~rsp_err_r & ~rsp_wr_r) begin
            if (rsp_owner_r) begin
                d_rsp_rdata = mem_read_data;
            end else begin
                i_rsp_rdata = mem_read_data;
            end
        end else begin
            i_rsp_rdata = {WIDTH{1'b0}};
            d_rsp_rdata = {WIDTH{1'b0}};
        end
    end

endmodule

// File: tb/tb_ssram_arbiter.sv
// Directed bench for ssram_arbiter with a 16-word ssram model (ADDR_BITS=4).
module tb_ssram_arbiter;

    logic        clk;
    logic        rst;
    logic        i_req_valid;
    logic        i_req_ready;
    logic [31:0] i_req_addr;
    logic        i_rsp_valid;
    logic [31:0] i_rsp_rdata;
    logic        i_rsp_err;
    logic        d_req_valid;
    logic        d_req_ready;
    logic [31:0] d_req_addr;
    logic        d_req_we;
    logic [3:0]  d_req_be;
    logic [31:0] d_req_wdata;
    logic        d_rsp_valid;
    logic [31:0] d_rsp_rdata;
    logic        d_rsp_err;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [3:0]  mem_write_byte_enable;
    logic        mem_write_enable;
    logic        mem_read_enable;
    logic [31:0] mem_read_data;
    logic        init_done;

    logic [31:0] mem_model [0:15] = '{default: 32'hDEADBEEF};
    int n_cmp;
    int n_fail;

    ssram_arbiter #(.WIDTH(32), .ADDR_BITS(4), .INIT_EN(1)) dut (
        .clk(clk), .rst(rst),
        .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
        .i_rsp_valid(i_rsp_valid), .i_rsp_rdata(i_rsp_rdata), .i_rsp_err(i_rsp_err),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
        .d_req_we(d_req_we), .d_req_be(d_req_be), .d_req_wdata(d_req_wdata),
        .d_rsp_valid(d_rsp_valid), .d_rsp_rdata(d_rsp_rdata), .d_rsp_err(d_rsp_err),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_write_byte_enable(mem_write_byte_enable), .mem_write_enable(mem_write_enable),
        .mem_read_enable(mem_read_enable), .mem_read_data(mem_read_data),
        .init_done(init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ssram model: byte-enabled write, registered read
    always @(posedge clk) begin
        if (mem_write_enable) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_write_byte_enable[b]) mem_model[mem_address[3:0]][8*b +: 8] <= mem_write_data[8*b +: 8];
            end
        end
        if (mem_read_enable) mem_read_data <= mem_model[mem_address[3:0]];
    end

    task automatic drive_i(input logic v, input logic [31:0] a);
        i_req_valid = v;
        i_req_addr  = a;
    endtask

    task automatic drive_d(input logic v, input logic we, input logic [31:0] a,
                           input logic [3:0] be, input logic [31:0] wd);
        d_req_valid = v;
        d_req_we    = we;
        d_req_addr  = a;
        d_req_be    = be;
        d_req_wdata = wd;
    endtask

    task automatic test_reset;
        @(negedge clk); #1;
        n_cmp++; if (i_req_ready !== 1'b0 || d_req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got i=%b d=%b want 0", i_req_ready, d_req_ready); end
        n_cmp++; if (i_rsp_valid !== 1'b0 || d_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got i=%b d=%b want 0", i_rsp_valid, d_rsp_valid); end
        n_cmp++; if (i_rsp_err !== 1'b0 || d_rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err: got i=%b d=%b want 0", i_rsp_err, d_rsp_err); end
        n_cmp++; if (i_rsp_rdata !== 32'd0 || d_rsp_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got i=%h d=%h want 0", i_rsp_rdata, d_rsp_rdata); end
        n_cmp++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL reset_init_done: got %b want 0", init_done); end
        n_cmp++; if (mem_write_enable !== 1'b0 || mem_read_enable !== 1'b0) begin n_fail++; $display("FAIL reset_mem_en: got we=%b re=%b want 0", mem_write_enable, mem_read_enable); end
        @(negedge clk);
    endtask

    task automatic test_init;
        rst = 1'b1;
        drive_i(1'b1, 32'h3C);      // waits through init
        for (int k = 0; k < 16; k++) begin
            #1;
            n_cmp++; if (mem_address !== 32'(k) || mem_write_enable !== 1'b1) begin n_fail++; $display("FAIL init_write[%0d]: got addr=%h we=%b want addr=%h we=1", k, mem_address, mem_write_enable, k); end
            n_cmp++; if (mem_write_data !== 32'd0 || mem_write_byte_enable !== 4'hF || mem_read_enable !== 1'b0) begin n_fail++; $display("FAIL init_drive[%0d]: got wd=%h be=%h re=%b want 0/f/0", k, mem_write_data, mem_write_byte_enable, mem_read_enable); end
            n_cmp++; if (i_req_ready !== 1'b0 || init_done !== 1'b0) begin n_fail++; $display("FAIL init_busy[%0d]: got ready=%b done=%b want 0/0", k, i_req_ready, init_done); end
            @(negedge clk);
        end
        #1;
        n_cmp++; if (init_done !== 1'b1) begin n_fail++; $display("FAIL init_done_rise: got %b want 1", init_done); end
        for (int k = 0; k < 16; k++) begin
            n_cmp++; if (mem_model[k] !== 32'd0) begin n_fail++; $display("FAIL init_zero[%0d]: got %h want 0", k, mem_model[k]); end
        end
        n_cmp++; if (i_req_ready !== 1'b1 || mem_read_enable !== 1'b1 || mem_address !== 32'd15) begin n_fail++; $display("FAIL init_pending_req: got ready=%b re=%b addr=%h want 1/1/f", i_req_ready, mem_read_enable, mem_address); end
        @(negedge clk);
        drive_i(1'b0, 32'h0);
        #1;
        n_cmp++; if (i_rsp_valid !== 1'b1 || i_rsp_rdata !== 32'd0 || i_rsp_err !== 1'b0) begin n_fail++; $display("FAIL init_read_3c: got v=%b d=%h e=%b want 1/0/0", i_rsp_valid, i_rsp_rdata, i_rsp_err); end
        @(negedge clk); #1;
        n_cmp++; if (i_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL init_rsp_one_cycle: got %b want 0", i_rsp_valid); end
    endtask

    task automatic test_byte_write;
        @(negedge clk);
        drive_d(1'b1, 1'b1, 32'h8, 4'b0101, 32'hAABBCCDD);
        #1;
        n_cmp++; if (d_req_ready !== 1'b1 || mem_write_enable !== 1'b1 || mem_address !== 32'd2 || mem_write_byte_enable !== 4'b0101 || mem_write_data !== 32'hAABBCCDD) begin
            n_fail++; $display("FAIL bw_drive: got rdy=%b we=%b a=%h be=%b wd=%h want 1/1/2/0101/aabbccdd", d_req_ready, mem_write_enable, mem_address, mem_write_byte_enable, mem_write_data); end
        @(negedge clk);
        drive_d(1'b1, 1'b0, 32'h8, 4'h0, 32'h0);
        #1;
        n_cmp++; if (d_rsp_valid !== 1'b1 || d_rsp_rdata !== 32'd0 || d_rsp_err !== 1'b0) begin n_fail++; $display("FAIL bw_ack: got v=%b d=%h e=%b want 1/0/0", d_rsp_valid, d_rsp_rdata, d_rsp_err); end
        n_cmp++; if (mem_read_enable !== 1'b1 || mem_write_enable !== 1'b0) begin n_fail++; $display("FAIL bw_read_drive: got re=%b we=%b want 1/0", mem_read_enable, mem_write_enable); end
        @(negedge clk);
        drive_d(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        #1;
        n_cmp++; if (d_rsp_valid !== 1'b1 || d_rsp_rdata !== 32'h00BB00DD) begin n_fail++; $display("FAIL bw_readback: got v=%b d=%h want 1/00bb00dd", d_rsp_valid, d_rsp_rdata); end
    endtask

    task automatic test_contention;
        logic [3:0] exp_i;
        exp_i = 4'b0101;            // bit k: cycle k grants I
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k < 4) begin
                drive_i(1'b1, 32'h0);
                drive_d(1'b1, 1'b0, 32'h8, 4'h0, 32'h0);
            end else begin
                drive_i(1'b0, 32'h0);
                drive_d(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
            end
            #1;
            if (k < 4) begin
                n_cmp++; if (i_req_ready !== exp_i[k] || d_req_ready !== ~exp_i[k]) begin n_fail++; $display("FAIL cont_grant[%0d]: got i=%b d=%b want i=%b", k, i_req_ready, d_req_ready, exp_i[k]); end
            end
            if (k > 0) begin
                if (exp_i[k-1]) begin
                    n_cmp++; if (i_rsp_valid !== 1'b1 || d_rsp_valid !== 1'b0 || i_rsp_rdata !== 32'd0) begin n_fail++; $display("FAIL cont_rsp_i[%0d]: got iv=%b dv=%b d=%h want 1/0/0", k-1, i_rsp_valid, d_rsp_valid, i_rsp_rdata); end
                end else begin
                    n_cmp++; if (d_rsp_valid !== 1'b1 || i_rsp_valid !== 1'b0 || d_rsp_rdata !== 32'h00BB00DD) begin n_fail++; $display("FAIL cont_rsp_d[%0d]: got dv=%b iv=%b d=%h want 1/0/00bb00dd", k-1, d_rsp_valid, i_rsp_valid, d_rsp_rdata); end
                end
            end
        end
    endtask

    task automatic test_out_of_range;
        @(negedge clk); drive_d(1'b1, 1'b1, 32'h0, 4'hF, 32'h12345678);
        @(negedge clk); drive_d(1'b1, 1'b1, 32'h4, 4'hF, 32'hCAFEF00D);
        @(negedge clk); drive_d(1'b1, 1'b1, 32'h40, 4'hF, 32'hFFFFFFFF);
        #1;
        n_cmp++; if (d_req_ready !== 1'b1 || mem_write_enable !== 1'b0 || mem_read_enable !== 1'b0) begin n_fail++; $display("FAIL oor_drive: got rdy=%b we=%b re=%b want 1/0/0", d_req_ready, mem_write_enable, mem_read_enable); end
        @(negedge clk); drive_d(1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
        #1;
        n_cmp++; if (d_rsp_valid !== 1'b1 || d_rsp_err !== 1'b1 || d_rsp_rdata !== 32'd0) begin n_fail++; $display("FAIL oor_rsp: got v=%b e=%b d=%h want 1/1/0", d_rsp_valid, d_rsp_err, d_rsp_rdata); end
        @(negedge clk);
        drive_d(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        drive_i(1'b1, 32'h100);
        #1;
        n_cmp++; if (d_rsp_rdata !== 32'h12345678 || d_rsp_err !== 1'b0) begin n_fail++; $display("FAIL oor_word0_kept: got d=%h e=%b want 12345678/0", d_rsp_rdata, d_rsp_err); end
        n_cmp++; if (i_req_ready !== 1'b1 || mem_read_enable !== 1'b0) begin n_fail++; $display("FAIL oor_i_drive: got rdy=%b re=%b want 1/0", i_req_ready, mem_read_enable); end
        @(negedge clk); drive_i(1'b0, 32'h0);
        #1;
        n_cmp++; if (i_rsp_valid !== 1'b1 || i_rsp_err !== 1'b1 || i_rsp_rdata !== 32'd0) begin n_fail++; $display("FAIL oor_i_rsp: got v=%b e=%b d=%h want 1/1/0", i_rsp_valid, i_rsp_err, i_rsp_rdata); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] addrs [0:2];
        logic [31:0] exp_d [0:2];
        addrs = '{32'h0, 32'h4, 32'h8};
        exp_d = '{32'h12345678, 32'hCAFEF00D, 32'h00BB00DD};
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k < 3) drive_d(1'b1, 1'b0, addrs[k], 4'h0, 32'h0);
            else drive_d(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
            #1;
            if (k < 3) begin
                n_cmp++; if (d_req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %b want 1", k, d_req_ready); end
            end
            if (k > 0 && k < 4) begin
                n_cmp++; if (d_rsp_valid !== 1'b1 || d_rsp_rdata !== exp_d[k-1]) begin n_fail++; $display("FAIL b2b_rsp[%0d]: got v=%b d=%h want 1/%h", k-1, d_rsp_valid, d_rsp_rdata, exp_d[k-1]); end
            end
            if (k == 4) begin
                n_cmp++; if (d_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_end: got %b want 0", d_rsp_valid); end
            end
        end
    endtask

    task automatic test_reset_midflight;
        logic seen;
        seen = 1'b0;
        @(negedge clk); drive_i(1'b1, 32'h4);
        #1;
        n_cmp++; if (i_req_ready !== 1'b1) begin n_fail++; $display("FAIL mid_accept: got %b want 1", i_req_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        drive_i(1'b0, 32'h0);
        #1;
        n_cmp++; if (i_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rsp_drop: got %b want 0", i_rsp_valid); end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); #1;
            if (i_rsp_valid !== 1'b0) seen = 1'b1;
        end
        n_cmp++; if (mem_write_enable !== 1'b0 || init_done !== 1'b0) begin n_fail++; $display("FAIL mid_in_reset: got we=%b done=%b want 0/0", mem_write_enable, init_done); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++; if (mem_address !== 32'd0 || mem_write_enable !== 1'b1) begin n_fail++; $display("FAIL mid_reinit_start: got a=%h we=%b want 0/1", mem_address, mem_write_enable); end
        for (int k = 0; k < 16; k++) begin
            @(negedge clk); #1;
            if (i_rsp_valid !== 1'b0) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL mid_lost_rsp: got seen=%b want 0", seen); end
        n_cmp++; if (init_done !== 1'b1) begin n_fail++; $display("FAIL mid_reinit_done: got %b want 1", init_done); end
        n_cmp++; if (mem_model[0] !== 32'd0 || mem_model[1] !== 32'd0) begin n_fail++; $display("FAIL mid_reinit_zero: got w0=%h w1=%h want 0/0", mem_model[0], mem_model[1]); end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b0;
        drive_i(1'b0, 32'h0);
        drive_d(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        test_reset();
        test_init();
        test_byte_write();
        test_contention();
        test_out_of_range();
        test_back_to_back();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
